seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
- Sequences the 8-bit binary-to-decimal seven-segment datapath for a board with one shared segment bus and three common-select digits.
- Accepts an 8-bit value through a valid/ready handshake and converts it to 3-digit BCD with a multi-cycle shift-add-3 (double-dabble) converter.
- Holds the result in a display register and time-multiplexes the three digits onto the shared bus with a free-running scan prescaler, with optional leading-zero blanking.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot; legal range >= 1.
- LZ_BLANK, 1: 1 blanks leading zero digits; 0 shows all three digits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is valid.
- in_data  in  8  unsigned binary value to display (0..255).
- in_ready  out  1  converter idle; can accept a value.
- done  out  1  one-cycle pulse when a conversion commits.
- bcd_out  out  12  display register {hundreds, tens, units}, 4 bits each.
- seg  out  7  segments, active-high; seg[0]=a ... seg[6]=g.
- dig_en  out  3  one-hot digit select, active-high; [0]=units, [1]=tens, [2]=hundreds.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, bcd_out=0, done=0, prescaler=0, digit index=0, seg=7'h00, dig_en=3'b000.
- Reset applied mid-conversion aborts the conversion: no done pulse, bcd_out=0.
- Converter FSM has three states: IDLE, CONVERT, COMMIT.
- in_ready=1 only in IDLE. A handshake occurs at an edge where in_valid && in_ready.
- At the handshake: shift reg = {12'b0, in_data}, iter=0, state -> CONVERT.
- CONVERT: each cycle, add 3 to every BCD nibble >= 5, then shift the 20-bit register left by 1.
- After 8 CONVERT cycles: bcd_out <= upper 12 bits, state -> COMMIT.
- COMMIT lasts 1 cycle with done=1; next state is IDLE.
- Timing: handshake at edge T; done high and new bcd_out visible in cycle T+9; in_ready high again in cycle T+10. Throughput is one value per 10 cycles.
- in_valid while in_ready=0 is ignored. The upstream holds data until the handshake; there is no buffering.
- Scanner runs free and independent of the FSM. The prescaler counts 0..SCAN_DIV-1.
- On prescaler wrap, digit index advances 0->1->2->0. With SCAN_DIV=1, the index advances every cycle.
- seg and dig_en are registered: their values are computed from the current index and bcd_out, and appear one cycle later.
- First cycle after reset release: dig_en=3'b001, seg=7'h3F.
- Decode, 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Nibbles 10..15 cannot occur; they decode to 7'h00.
- Blanking (LZ_BLANK=1):
  - hundreds==0 -> the hundreds slot outputs seg=00.
  - hundreds==0 && tens==0 -> the tens slot outputs seg=00.
  - Units are never blanked.
  - dig_en stays one-hot even when a digit is blanked.
- A bcd_out update mid-slot takes effect on the next registered output. The prescaler and index are not disturbed.

Decomposition:
- seg7_pkg holds:
  - the state enum (IDLE, CONVERT, COMMIT)
  - the SEG_0..SEG_9 and SEG_BLANK constants
  - a decode function nibble -> 7-bit segments
  - the digit-index typedef (2 bits)
- One sub-module, bin2bcd_seq: the converter FSM plus shift register, exposing the valid/ready/done/bcd interface.
- The top level adds the display register and the scanner.

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> seg=00, dig_en=000, in_ready=1, bcd_out=000. Release -> next cycle dig_en=001, seg=3F.
- Load 255 with SCAN_DIV=4:
  - in_ready=0 for cycles T+1..T+9; single done pulse at T+9; bcd_out=12'h255.
  - Scan shows 6D on 001, 6D on 010, 5B on 100; each slot lasts 4 cycles.
- Load 7:
  - LZ_BLANK=1 -> units 07, tens 00, hundreds 00.
  - LZ_BLANK=0 -> 07, 3F, 3F.
  - Load 40 with LZ_BLANK=1 -> 3F, 66, 00.
- Hold in_valid with 100, then change to 200 after the first handshake -> bcd_out 100 then 200, done pulses exactly 10 cycles apart, no value dropped or duplicated.
- Load 128, then assert rst_n=0 at T+4 -> no done pulse, bcd_out=000, in_ready=1 after release. A following load of 5 gives bcd_out=005.
- Sweep 0..255 back-to-back -> bcd_out at each done equals {i/100, (i/10)%10, i%10}.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, segment constants and nibble decoder for the seven-segment
// scan controller and its binary-to-BCD converter.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    typedef logic [1:0] digit_idx_t;

    localparam int BCD_ITERS = 8;

    // Segment patterns, bit 0 = a ... bit 6 = g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Value-in handshake plus conversion result bus between an upstream source
// and the seven-segment scan controller.
interface seg7_scan_controller_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        done;
    logic [11:0] bcd_out;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output done,
        output bcd_out
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one
// iteration per clock, with a one-cycle commit state.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        done,
    output logic        load,
    output logic [11:0] bcd
);

    state_t      state_reg;
    state_t      state_next;
    logic [19:0] shift_reg;
    logic [19:0] shift_adj;
    logic [19:0] shift_next;
    logic [2:0]  iter_reg;
    logic        last_iter;

    assign last_iter = (iter_reg == 3'(BCD_ITERS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CONVERT;
            CONVERT: if (last_iter) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == IDLE);
        done     = (state_reg == COMMIT);
        load     = (state_reg == CONVERT) && last_iter;
    end

    // Add-3 correction on each BCD nibble before the shift
    assign shift_adj[7:0] = shift_reg[7:0];
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            localparam int LO = 8 + 4 * gi;
            assign shift_adj[LO +: 4] = (shift_reg[LO +: 4] >= 4'd5)
                                      ? shift_reg[LO +: 4] + 4'd3
                                      : shift_reg[LO +: 4];
        end
    endgenerate

    assign shift_next = shift_adj << 1;
    assign bcd        = shift_next[19:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
            iter_reg  <= '0;
        end else if ((state_reg == IDLE) && in_valid) begin
            shift_reg <= {12'b0, in_data};
            iter_reg  <= '0;
        end else if (state_reg == CONVERT) begin
            shift_reg <= shift_next;
            iter_reg  <= iter_reg + 3'd1;
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Binary value in, three multiplexed seven-segment digits out: converter,
// display register and free-running digit scanner.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int LZ_BLANK = 1
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    seg7_scan_controller_if.slave   bus,
    output logic [6:0]              seg,
    output logic [2:0]              dig_en
);

    localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);

    logic        load;
    logic [11:0] bcd_conv;
    logic [11:0] bcd_out_reg;

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.in_valid),
        .in_data  (bus.in_data),
        .in_ready (bus.in_ready),
        .done     (bus.done),
        .load     (load),
        .bcd      (bcd_conv)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_out_reg <= '0;
        end else if (load) begin
            bcd_out_reg <= bcd_conv;
        end
    end

    assign bus.bcd_out = bcd_out_reg;

    logic [PW-1:0] pre_reg;
    digit_idx_t    idx_reg;
    digit_idx_t    idx_next;
    logic          wrap;

    assign wrap     = (pre_reg == PRE_LAST);
    assign idx_next = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;

    // Scanner never looks at the converter; display updates land mid-slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else begin
            pre_reg <= wrap ? '0 : pre_reg + PW'(1);
            if (wrap) begin
                idx_reg <= idx_next;
            end
        end
    end

    logic [6:0] digit_seg [3];
    logic       blank_tens;
    logic       blank_hund;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dec
            assign digit_seg[gi] = seg_decode(bcd_out_reg[4*gi +: 4]);
        end
    endgenerate

    assign blank_hund = (LZ_BLANK != 0) && (bcd_out_reg[11:8] == 4'd0);
    assign blank_tens = blank_hund && (bcd_out_reg[7:4] == 4'd0);

    logic [6:0] seg_next;
    logic [2:0] dig_en_next;
    logic [6:0] seg_reg;
    logic [2:0] dig_en_reg;

    always_comb begin
        seg_next    = SEG_BLANK;
        dig_en_next = 3'b000;
        case (idx_reg)
            2'd0: begin
                dig_en_next = 3'b001;
                seg_next    = digit_seg[0];
            end
            2'd1: begin
                dig_en_next = 3'b010;
                seg_next    = blank_tens ? SEG_BLANK : digit_seg[1];
            end
            2'd2: begin
                dig_en_next = 3'b100;
                seg_next    = blank_hund ? SEG_BLANK : digit_seg[2];
            end
            default: begin
                dig_en_next = 3'b000;
                seg_next    = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_reg    <= SEG_BLANK;
            dig_en_reg <= 3'b000;
        end else begin
            seg_reg    <= seg_next;
            dig_en_reg <= dig_en_next;
        end
    end

    assign seg    = seg_reg;
    assign dig_en = dig_en_reg;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: three instances with different
// scan divider / blanking settings share one stimulus stream.
module tb_seg7_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    logic [11:0] cur_bcd;

    always #5 clk = ~clk;

    seg7_scan_controller_if a_if ();
    seg7_scan_controller_if b_if ();
    seg7_scan_controller_if c_if ();

    assign a_if.in_valid = in_valid;
    assign a_if.in_data  = in_data;
    assign b_if.in_valid = in_valid;
    assign b_if.in_data  = in_data;
    assign c_if.in_valid = in_valid;
    assign c_if.in_data  = in_data;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [2:0] den_a, den_b, den_c;

    seg7_scan_controller #(.SCAN_DIV(4), .LZ_BLANK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if), .seg(seg_a), .dig_en(den_a));
    seg7_scan_controller #(.SCAN_DIV(4), .LZ_BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if), .seg(seg_b), .dig_en(den_b));
    seg7_scan_controller #(.SCAN_DIV(1), .LZ_BLANK(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if), .seg(seg_c), .dig_en(den_c));

    // Edges seen with reset released since the last reset
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx, input int lz);
        logic [3:0] h = b[11:8];
        logic [3:0] t = b[7:4];
        logic [3:0] u = b[3:0];
        if (idx == 0) return dec(u);
        if (idx == 1) return (lz != 0 && h == 0 && t == 0) ? 7'h00 : dec(t);
        return (lz != 0 && h == 0) ? 7'h00 : dec(h);
    endfunction

    function automatic logic [11:0] bcd3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic scan_check(input string tag, input int n);
        int ia;
        int ic;
        logic [2:0] one;
        for (int k = 0; k < n; k++) begin
            one = 3'b001;
            ia  = ((cyc - 1) / 4) % 3;
            ic  = (cyc - 1) % 3;
            check({tag, "_den_a"}, 32'(den_a), 32'(one << ia));
            check({tag, "_seg_a"}, 32'(seg_a), 32'(exp_seg(cur_bcd, ia, 1)));
            check({tag, "_den_b"}, 32'(den_b), 32'(one << ia));
            check({tag, "_seg_b"}, 32'(seg_b), 32'(exp_seg(cur_bcd, ia, 0)));
            check({tag, "_den_c"}, 32'(den_c), 32'(one << ic));
            check({tag, "_seg_c"}, 32'(seg_c), 32'(exp_seg(cur_bcd, ic, 1)));
            tick;
        end
    endtask

    task automatic do_load(input string tag, input logic [7:0] v, input logic [11:0] exp_bcd);
        int   n;
        int   k;
        int   ready_bad;
        logic seen;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!a_if.in_ready && n < 40) begin
            tick;
            n++;
        end
        check({tag, "_accept"}, 32'(a_if.in_ready), 32'd1);
        tick;
        in_valid  = 1'b0;
        k         = 0;
        ready_bad = 0;
        seen      = 1'b0;
        while (!seen && k < 20) begin
            if (a_if.in_ready) ready_bad++;
            if (a_if.done) begin
                seen = 1'b1;
            end else begin
                tick;
                k++;
            end
        end
        check({tag, "_lat"}, 32'(k + 1), 32'd9);
        check({tag, "_busy"}, 32'(ready_bad), 32'd0);
        check({tag, "_bcd"}, 32'(a_if.bcd_out), 32'(exp_bcd));
        check({tag, "_bcd_bc"}, {8'h0, b_if.bcd_out, c_if.bcd_out}, {8'h0, exp_bcd, exp_bcd});
        check({tag, "_flags_bc"}, 32'({b_if.done, c_if.done, b_if.in_ready, c_if.in_ready}), 32'b1100);
        $display("[TB] load %0d -> bcd_out %03h", v, a_if.bcd_out);
        tick;
        check({tag, "_pulse"}, 32'(a_if.done), 32'd0);
        check({tag, "_ready"}, 32'(a_if.in_ready), 32'd1);
        cur_bcd = exp_bcd;
    endtask

    initial begin
        int   k;
        int   dones;
        int   hs;
        int   t1;
        int   extra;
        logic fire;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        cur_bcd  = 12'h000;

        tick;
        tick;
        check("rst_seg", 32'(seg_a), 32'h00);
        check("rst_den", 32'(den_a), 32'h0);
        check("rst_den_c", 32'(den_c), 32'h0);
        check("rst_ready", 32'(a_if.in_ready), 32'd1);
        check("rst_bcd", 32'(a_if.bcd_out), 32'h000);
        check("rst_done", 32'(a_if.done), 32'd0);

        rst_n = 1'b1;
        tick;
        check("rel_den", 32'(den_a), 32'h1);
        check("rel_seg", 32'(seg_a), 32'h3F);
        scan_check("rst_scan", 12);

        do_load("v255", 8'd255, 12'h255);
        scan_check("scan255", 13);
        do_load("v7", 8'd7, 12'h007);
        scan_check("scan7", 13);
        do_load("v40", 8'd40, 12'h040);
        scan_check("scan40", 13);

        // Held valid: 100 then 200, exactly one handshake each
        in_valid = 1'b1;
        in_data  = 8'd100;
        dones = 0;
        hs    = 0;
        t1    = 0;
        k     = 0;
        while (dones < 2 && k < 40) begin
            if (a_if.done) begin
                dones++;
                if (dones == 1) begin
                    check("hold_bcd1", 32'(a_if.bcd_out), 32'h100);
                    t1 = k;
                end else begin
                    check("hold_bcd2", 32'(a_if.bcd_out), 32'h200);
                    check("hold_gap", 32'(k - t1), 32'd10);
                    in_valid = 1'b0;
                end
            end
            if (dones < 2) begin
                fire = a_if.in_valid && a_if.in_ready;
                tick;
                k++;
                if (fire) begin
                    hs++;
                    if (hs == 1) in_data = 8'd200;
                end
            end
        end
        in_valid = 1'b0;
        check("hold_dones", 32'(dones), 32'd2);
        check("hold_hs", 32'(hs), 32'd2);
        $display("[TB] held-valid pair -> bcd_out %03h", a_if.bcd_out);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (a_if.done) extra++;
        end
        check("hold_extra", 32'(extra), 32'd0);
        cur_bcd = 12'h200;

        // Reset lands at handshake + 4 edges
        in_valid = 1'b1;
        in_data  = 8'd128;
        check("abort_ready", 32'(a_if.in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (a_if.done) extra++;
        end
        rst_n = 1'b0;
        tick;
        if (a_if.done) extra++;
        check("abort_den", 32'(den_a), 32'h0);
        tick;
        if (a_if.done) extra++;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (a_if.done) extra++;
        end
        check("abort_nodone", 32'(extra), 32'd0);
        check("abort_bcd", 32'(a_if.bcd_out), 32'h000);
        check("abort_ready2", 32'(a_if.in_ready), 32'd1);
        $display("[TB] aborted load 128 -> bcd_out %03h", a_if.bcd_out);
        cur_bcd = 12'h000;

        do_load("v5", 8'd5, 12'h005);
        scan_check("scan5", 8);

        for (int i = 0; i < 256; i++) begin
            do_load($sformatf("sw%0d", i), 8'(i), bcd3(i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
